// File: rtl/hello_world_nios2_qsys_div_cell_if.sv
// ---------------------------------------------------------------------------
// hello_world_nios2_qsys_div_cell_if
// Start/done handshake bundle between the A-stage and the iterative divider.
//   A_div_src1 / A_div_src2   dividend / divisor
//   A_div_signed              1 = two's-complement operands
//   A_div_start               request, accepted when the divider is idle or done
//   A_div_busy                operation in flight
//   A_div_done                one-cycle pulse, results valid from this cycle
//   A_div_cell_result         quotient
//   A_div_cell_remainder      remainder
//   A_div_by_zero             divisor of the reported operation was zero
// master = A-stage side, slave = divider side.
// ---------------------------------------------------------------------------
interface hello_world_nios2_qsys_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_start;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_cell_result;
    logic [WIDTH-1:0] A_div_cell_remainder;
    logic             A_div_by_zero;

    modport master (
        output A_div_src1, A_div_src2, A_div_signed, A_div_start,
        input  A_div_busy, A_div_done, A_div_cell_result, A_div_cell_remainder,
               A_div_by_zero
    );

    modport slave (
        input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
        output A_div_busy, A_div_done, A_div_cell_result, A_div_cell_remainder,
               A_div_by_zero
    );
endinterface

// File: rtl/hello_world_nios2_qsys_div_cell.sv
// ---------------------------------------------------------------------------
// hello_world_nios2_qsys_div_cell
// Iterative radix-2 restoring divider with signed/unsigned div semantics and a
// fixed latency of WIDTH+3 cycles from an accepted start to the done pulse.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   div     handshake/operand/result bundle (slave side)
// ---------------------------------------------------------------------------
module hello_world_nios2_qsys_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    hello_world_nios2_qsys_div_cell_if.slave div
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic             signed_q;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs_mag;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             bz_q;

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             by_zero;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sign1;
    logic             sign2;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return '0 - x;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a start in the DONE cycle chains straight into PREP
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (div.A_div_start) next_state = PREP;
            PREP:    next_state = ITER;
            ITER:    if (cnt == LAST) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = div.A_div_start ? PREP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring step: the (WIDTH+1)-bit subtract's MSB is the borrow,
    // so a clear MSB means the shifted remainder covers the divisor.
    always_comb begin
        sign1   = signed_q & src1_q[WIDTH-1];
        sign2   = signed_q & src2_q[WIDTH-1];
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_mag};
    end

    // Datapath: operand capture, magnitude prep, iteration and sign fix-up.
    // A zero divisor runs through unchanged: every step subtracts zero, which
    // yields an all-ones quotient and the dividend magnitude as remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            src1_q    <= '0;
            src2_q    <= '0;
            signed_q  <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            bz_q      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (div.A_div_start) begin
                        src1_q   <= div.A_div_src1;
                        src2_q   <= div.A_div_src2;
                        signed_q <= div.A_div_signed;
                    end
                end
                PREP: begin
                    quo     <= sign1 ? negate(src1_q) : src1_q;
                    dvs_mag <= sign2 ? negate(src2_q) : src2_q;
                    rem     <= '0;
                    cnt     <= '0;
                    q_neg   <= (sign1 ^ sign2) & (src2_q != '0);
                    r_neg   <= sign1;
                    bz_q    <= (src2_q == '0);
                end
                ITER: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_ONE;
                end
                FIX: begin
                    result    <= q_neg ? negate(quo) : quo;
                    remainder <= r_neg ? negate(rem) : rem;
                    by_zero   <= bz_q;
                end
                default: ;
            endcase
        end
    end

    assign div.A_div_busy           = (state == PREP) || (state == ITER) || (state == FIX);
    assign div.A_div_done           = (state == DONE);
    assign div.A_div_cell_result    = result;
    assign div.A_div_cell_remainder = remainder;
    assign div.A_div_by_zero        = by_zero;

endmodule

// File: tb/tb_hello_world_nios2_qsys_div_cell.sv
// ---------------------------------------------------------------------------
// tb_hello_world_nios2_qsys_div_cell
// Directed bench for the iterative divider: latency, busy window, signed and
// unsigned results, divide-by-zero, overflow, ignored starts, back-to-back
// operation and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_hello_world_nios2_qsys_div_cell;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hello_world_nios2_qsys_div_cell_if #(.WIDTH(WIDTH)) div_if ();

    hello_world_nios2_qsys_div_cell #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div_if)
    );

    // Single comparison point: counts the check and reports any mismatch
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present operands with start high for one edge; returns just after
    // that edge, i.e. at the beginning of cycle 1 of the operation.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic s);
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
        div_if.A_div_signed = s;
        div_if.A_div_start  = 1'b1;
        @(posedge clk);
        #1;
        div_if.A_div_start  = 1'b0;
    endtask

    // Walk cycles 1..40 at the falling edge, noting the busy window and the
    // cycle of the done pulse; optionally hammer start with other operands
    // during cycles 5-20. Returns at the falling edge of the done cycle.
    task automatic wait_done(input bit inject, output int done_cycle,
                             output bit busy_ok);
        done_cycle = -1;
        busy_ok    = 1'b1;
        for (int k = 1; k <= 40 && done_cycle < 0; k++) begin
            @(negedge clk);
            if (div_if.A_div_busy !== (k <= 34)) busy_ok = 1'b0;
            if (div_if.A_div_done === 1'b1) done_cycle = k;
            if (inject) begin
                if (k >= 5 && k <= 20) begin
                    div_if.A_div_start  = 1'b1;
                    div_if.A_div_src1   = 32'd77;
                    div_if.A_div_src2   = 32'd7;
                    div_if.A_div_signed = 1'b1;
                end else begin
                    div_if.A_div_start  = 1'b0;
                end
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic s,
                             input logic [31:0] exp_q, input logic [31:0] exp_r,
                             input logic exp_bz, input bit inject);
        int done_cycle;
        bit busy_ok;
        apply_stimulus(a, b, s);
        wait_done(inject, done_cycle, busy_ok);
        check_output({tag, "_done_cycle"}, done_cycle, 32'd35);
        check_output({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check_output({tag, "_result"}, div_if.A_div_cell_result, exp_q);
        check_output({tag, "_remainder"}, div_if.A_div_cell_remainder, exp_r);
        check_output({tag, "_by_zero"}, {31'd0, div_if.A_div_by_zero}, {31'd0, exp_bz});
    endtask

    task automatic idle_gap();
        repeat (3) @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        int done_seen;

        reset               = 1'b1;
        div_if.A_div_src1   = '0;
        div_if.A_div_src2   = '0;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check_output("rst_done", {31'd0, div_if.A_div_done}, 32'd0);
        check_output("rst_result", div_if.A_div_cell_result, 32'd0);
        check_output("rst_remainder", div_if.A_div_cell_remainder, 32'd0);
        check_output("rst_by_zero", {31'd0, div_if.A_div_by_zero}, 32'd0);
        reset = 1'b0;
        idle_gap();

        $display("[TB] unsigned 100/7");
        run_check("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        check_output("u100_7_done_pulse_end", {31'd0, div_if.A_div_done}, 32'd0);
        check_output("u100_7_result_hold", div_if.A_div_cell_result, 32'd14);
        idle_gap();

        $display("[TB] signed cases");
        run_check("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_gap();
        run_check("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        idle_gap();

        $display("[TB] divide by zero");
        run_check("u_div0", 32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        idle_gap();
        run_check("s_div0", 32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        idle_gap();
        run_check("s_neg_div0", 32'hFFFF_FFF9, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
        idle_gap();

        $display("[TB] overflow corner");
        run_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        idle_gap();
        run_check("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        idle_gap();

        $display("[TB] ignored starts then back-to-back");
        run_check("ignore", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, 1'b1);
        run_check("b2b_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
        idle_gap();
        run_check("u_beef", 32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0);
        idle_gap();

        $display("[TB] reset mid-operation");
        apply_stimulus(32'h1234_5678, 32'd3, 1'b0);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midrst_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check_output("midrst_done", {31'd0, div_if.A_div_done}, 32'd0);
        check_output("midrst_result", div_if.A_div_cell_result, 32'd0);
        check_output("midrst_remainder", div_if.A_div_cell_remainder, 32'd0);
        check_output("midrst_by_zero", {31'd0, div_if.A_div_by_zero}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_if.A_div_done === 1'b1) done_seen++;
        end
        check_output("midrst_no_done", done_seen, 32'd0);
        run_check("post_rst_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0);
        idle_gap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
